// File: rtl/multi_threshold_controller.sv
// Multi-channel hysteresis climate controller: periodic sensor sampling, per-channel actuators, command port.
// Latency: sample_valid -> act update 2 cycles; commands take effect 1 cycle after cmd_valid.
// Backpressure: none; sensor handshake bounded by ACK_TIMEOUT, report_req held until report_done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   sensor_req / sample_valid / sample_data   sensor request level, sample pulse and packed readings
//   cmd_valid/cmd_op/cmd_ch/cmd_val, cmd_err  command strobe, fields, reject pulse
//   act, forced, sensor_fault, samples_q      actuator outputs, manual-mode flags, fault flag, latched readings
//   report_req / report_done                  metrics report request level and its completion
module multi_threshold_controller #(
  parameter int                   N_CH        = 2,
  parameter int                   DW          = 8,
  parameter int                   TICK_CYCLES = 1000000,
  parameter int                   ACK_TIMEOUT = 50000,
  parameter logic [N_CH-1:0]      POL         = 2'b01,
  parameter logic [N_CH*DW-1:0]   HI_RST      = {8'd63, 8'd34},
  parameter logic [N_CH*DW-1:0]   LO_RST      = {8'd42, 8'd1}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 sensor_req,
  input  logic                 sample_valid,
  input  logic [N_CH*DW-1:0]   sample_data,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [2:0]           cmd_ch,
  input  logic [DW-1:0]        cmd_val,
  output logic                 cmd_err,
  output logic [N_CH-1:0]      act,
  output logic [N_CH-1:0]      forced,
  output logic                 sensor_fault,
  output logic [N_CH*DW-1:0]   samples_q,
  output logic                 report_req,
  input  logic                 report_done
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    tick_cnt;
  logic [WW-1:0]    wait_cnt;
  logic             tick;
  logic             accept;
  logic             timeout;
  logic [DW-1:0]    hi [N_CH];
  logic [DW-1:0]    lo [N_CH];
  logic [DW-1:0]    sel_hi, sel_lo, s;
  logic             cmd_ok;
  logic [N_CH-1:0]  act_nx, forced_nx;
  logic             report_set;

  assign tick       = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign sensor_req = (state == WAIT);
  assign accept     = (state == WAIT) && sample_valid;
  // A sample arriving on the last wait cycle still counts as a success.
  assign timeout    = (state == WAIT) && !sample_valid && (wait_cnt == WW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      wait_cnt <= '0;
      state    <= IDLE;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      wait_cnt <= (state == WAIT) ? wait_cnt + WW'(1) : '0;
      state    <= state_nx;
    end
  end

  // A tick seen while WAIT is active is dropped; EVAL never holds req high, so a tick there starts a new wait.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = WAIT;
      WAIT:    if (sample_valid) state_nx = EVAL;
               else if (timeout) state_nx = IDLE;
      EVAL:    state_nx = tick ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command legality; channel lookup by loop keeps out-of-range cmd_ch from indexing the arrays.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    cmd_ok = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(cmd_ch) == c) begin
        cmd_ok = 1'b1;
        sel_hi = hi[c];
        sel_lo = lo[c];
      end
    end
    case (cmd_op)
      3'd0:             if (cmd_val < sel_lo) cmd_ok = 1'b0;
      3'd1:             if (cmd_val > sel_hi) cmd_ok = 1'b0;
      3'd2, 3'd3, 3'd4: ;
      default:          cmd_ok = 1'b0;
    endcase
  end

  // Evaluation uses registered thresholds/mode; an accepted force command then overrides its own channel.
  always_comb begin
    act_nx     = act;
    forced_nx  = forced;
    report_set = 1'b0;
    s          = '0;
    if (state == EVAL) begin
      report_set = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        s = samples_q[c*DW +: DW];
        if (!forced[c]) begin
          if (POL[c]) begin
            if (s > hi[c])      act_nx[c] = 1'b1;
            else if (s < lo[c]) act_nx[c] = 1'b0;
          end else begin
            if (s < lo[c])      act_nx[c] = 1'b1;
            else if (s > hi[c]) act_nx[c] = 1'b0;
          end
        end
      end
    end
    if (timeout) begin
      report_set = 1'b1;
      for (int c = 0; c < N_CH; c++)
        if (!forced[c]) act_nx[c] = 1'b0;
    end
    if (cmd_valid && cmd_ok) begin
      for (int c = 0; c < N_CH; c++) begin
        if (int'(cmd_ch) == c) begin
          case (cmd_op)
            3'd2:    begin forced_nx[c] = 1'b1; act_nx[c] = 1'b1; end
            3'd3:    begin forced_nx[c] = 1'b1; act_nx[c] = 1'b0; end
            3'd4:    forced_nx[c] = 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        hi[c] <= HI_RST[c*DW +: DW];
        lo[c] <= LO_RST[c*DW +: DW];
      end
      act          <= '0;
      forced       <= '0;
      cmd_err      <= 1'b0;
      sensor_fault <= 1'b0;
      samples_q    <= '0;
      report_req   <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cmd_valid && cmd_ok && int'(cmd_ch) == c) begin
          if (cmd_op == 3'd0) hi[c] <= cmd_val;
          if (cmd_op == 3'd1) lo[c] <= cmd_val;
        end
      end
      act     <= act_nx;
      forced  <= forced_nx;
      cmd_err <= cmd_valid && !cmd_ok;
      if (accept) begin
        samples_q    <= sample_data;
        sensor_fault <= 1'b0;
      end else if (timeout) begin
        sensor_fault <= 1'b1;
      end
      // Set has priority over a same-cycle report_done.
      if (report_set)       report_req <= 1'b1;
      else if (report_done) report_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_threshold_controller.sv
module tb_multi_threshold_controller;
  localparam int N = 2, DW = 8, TICK = 20, ACK = 8;
  localparam logic [1:0] POL = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sensor_req, sample_valid, cmd_valid, cmd_err, sensor_fault, report_req, report_done;
  logic [15:0]   sample_data, samples_q;
  logic [2:0]    cmd_op, cmd_ch;
  logic [7:0]    cmd_val;
  logic [1:0]    act, forced;

  int checks = 0;
  int errors = 0;

  multi_threshold_controller #(.N_CH(N), .DW(DW), .TICK_CYCLES(TICK), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_req(sensor_req), .sample_valid(sample_valid),
    .sample_data(sample_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .cmd_val(cmd_val), .cmd_err(cmd_err), .act(act), .forced(forced),
    .sensor_fault(sensor_fault), .samples_q(samples_q), .report_req(report_req),
    .report_done(report_done));

  always #5 clk = ~clk;

  // Reference model: observable outputs plus thresholds, advanced once per clock edge.
  int          m_edges, m_age;
  int          m_hi [N];
  int          m_lo [N];
  bit          m_req, m_eval, m_fault, m_rep, m_err;
  logic [1:0]  m_act, m_forced;
  logic [15:0] m_samp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_age = 0;
    m_hi[0] = 34; m_hi[1] = 63; m_lo[0] = 1; m_lo[1] = 42;
    m_req = 0; m_eval = 0; m_fault = 0; m_rep = 0; m_err = 0;
    m_act = '0; m_forced = '0; m_samp = '0;
  endtask

  task automatic model_update();
    bit tick, acc, tmo, ok, req_n;
    int s;
    logic [1:0] act_n, frc_n;
    tick  = (m_edges % TICK) == TICK - 1;
    acc   = m_req && sample_valid;
    tmo   = m_req && !sample_valid && (m_age == ACK);
    act_n = m_act;
    frc_n = m_forced;
    if (m_eval) begin
      for (int c = 0; c < N; c++) begin
        s = int'(m_samp[c*8 +: 8]);
        if (!m_forced[c]) begin
          if (POL[c]) begin
            if (s > m_hi[c]) act_n[c] = 1'b1;
            else if (s < m_lo[c]) act_n[c] = 1'b0;
          end else begin
            if (s < m_lo[c]) act_n[c] = 1'b1;
            else if (s > m_hi[c]) act_n[c] = 1'b0;
          end
        end
      end
    end
    if (tmo) for (int c = 0; c < N; c++) if (!m_forced[c]) act_n[c] = 1'b0;
    m_err = 0;
    if (cmd_valid) begin
      ok = (int'(cmd_ch) < N) && (cmd_op <= 3'd4);
      if (ok && cmd_op == 3'd0 && int'(cmd_val) < m_lo[cmd_ch]) ok = 0;
      if (ok && cmd_op == 3'd1 && int'(cmd_val) > m_hi[cmd_ch]) ok = 0;
      if (!ok) m_err = 1;
      else case (cmd_op)
        3'd0: m_hi[cmd_ch] = int'(cmd_val);
        3'd1: m_lo[cmd_ch] = int'(cmd_val);
        3'd2: begin frc_n[cmd_ch] = 1'b1; act_n[cmd_ch] = 1'b1; end
        3'd3: begin frc_n[cmd_ch] = 1'b1; act_n[cmd_ch] = 1'b0; end
        default: frc_n[cmd_ch] = 1'b0;
      endcase
    end
    if (m_eval || tmo) m_rep = 1;
    else if (report_done) m_rep = 0;
    if (acc) begin m_samp = sample_data; m_fault = 0; end
    else if (tmo) m_fault = 1;
    if (acc || tmo) req_n = 0;
    else req_n = m_req ? 1'b1 : tick;
    m_age    = req_n ? (m_req ? m_age + 1 : 1) : 0;
    m_req    = req_n;
    m_eval   = acc;
    m_act    = act_n;
    m_forced = frc_n;
    m_edges++;
  endtask

  task automatic compare_all();
    chk("sensor_req", 32'(sensor_req), 32'(m_req));
    chk("act", 32'(act), 32'(m_act));
    chk("forced", 32'(forced), 32'(m_forced));
    chk("sensor_fault", 32'(sensor_fault), 32'(m_fault));
    chk("samples_q", 32'(samples_q), 32'(m_samp));
    chk("report_req", 32'(report_req), 32'(m_rep));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    sample_valid = 0; cmd_valid = 0; report_done = 0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60 && !m_req; i++) cycle();
    if (!m_req) chk("req_wait", 32'(sensor_req), 32'd1);
  endtask

  task automatic sample(input logic [15:0] d);
    wait_req();
    sample_valid = 1; sample_data = d;
    cycle();
    cycle();
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] ch, input logic [7:0] val);
    cmd_valid = 1; cmd_op = op; cmd_ch = ch; cmd_val = val;
    cycle();
  endtask

  initial begin
    rst_n = 0; sample_valid = 0; sample_data = '0; cmd_valid = 0;
    cmd_op = '0; cmd_ch = '0; cmd_val = '0; report_done = 0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1;

    // Tick then sensor timeout with no stimulus.
    repeat (19) cycle();
    chk("req_before_wrap", 32'(sensor_req), 32'd0);
    cycle();
    chk("req_rise", 32'(sensor_req), 32'd1);
    repeat (8) cycle();
    chk("timeout_fault", 32'(sensor_fault), 32'd1);
    chk("timeout_act", 32'(act), 32'd0);
    chk("timeout_report", 32'(report_req), 32'd1);
    report_done = 1; cycle();
    chk("report_clear", 32'(report_req), 32'd0);

    // Hysteresis in both polarities.
    sample({8'd40, 8'd35});
    chk("eval_40_35", 32'(act), 32'b11);
    chk("fault_cleared", 32'(sensor_fault), 32'd0);
    sample({8'd50, 8'd20});
    chk("eval_hold", 32'(act), 32'b11);
    chk("report_two_evals", 32'(report_req), 32'd1);
    sample({8'd64, 8'd0});
    chk("eval_off", 32'(act), 32'b00);
    report_done = 1; cycle();
    chk("report_done", 32'(report_req), 32'd0);

    // Threshold ordering rules.
    send_cmd(3'd0, 3'd0, 8'd0);
    chk("hi_below_lo_err", 32'(cmd_err), 32'd1);
    cycle();
    chk("err_pulse", 32'(cmd_err), 32'd0);
    sample({8'd64, 8'd20});
    chk("hi0_kept", 32'(act), 32'b00);
    send_cmd(3'd1, 3'd1, 8'd63);
    chk("lo_eq_hi_ok", 32'(cmd_err), 32'd0);
    sample({8'd62, 8'd20});
    chk("lo1_63", 32'(act), 32'b10);
    send_cmd(3'd5, 3'd0, 8'd0);
    chk("bad_op_err", 32'(cmd_err), 32'd1);
    send_cmd(3'd2, 3'd2, 8'd0);
    chk("bad_ch_err", 32'(cmd_err), 32'd1);

    // Force on colliding with an EVAL that would turn the channel off.
    wait_req();
    sample_valid = 1; sample_data = {8'd64, 8'd20};
    cycle();
    cmd_valid = 1; cmd_op = 3'd2; cmd_ch = 3'd1; cmd_val = '0;
    cycle();
    chk("force_wins_act", 32'(act), 32'b10);
    chk("force_wins_forced", 32'(forced), 32'b10);
    sample({8'd64, 8'd20});
    chk("forced_holds", 32'(act), 32'b10);
    send_cmd(3'd4, 3'd1, 8'd0);
    chk("auto_act_hold", 32'(act), 32'b10);
    chk("auto_forced", 32'(forced), 32'b00);
    sample({8'd64, 8'd20});
    chk("auto_resumes", 32'(act), 32'b00);

    // Async reset mid-WAIT restores thresholds.
    send_cmd(3'd0, 3'd0, 8'd50);
    chk("hi0_50_ok", 32'(cmd_err), 32'd0);
    wait_req();
    cycle(); cycle();
    #2 rst_n = 0;
    #1;
    chk("arst_req", 32'(sensor_req), 32'd0);
    chk("arst_act", 32'(act), 32'd0);
    @(negedge clk);
    #1 rst_n = 1;
    model_reset();
    sample({8'd0, 8'd35});
    chk("arst_hi_restored", 32'(act), 32'b11);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      sample_valid = m_req ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
      sample_data  = {8'($urandom % 72), 8'($urandom % 72)};
      cmd_valid    = ($urandom % 6 == 0);
      cmd_op       = 3'($urandom % 6);
      cmd_ch       = ($urandom % 5 == 0) ? 3'(2 + $urandom % 6) : 3'($urandom % 2);
      cmd_val      = 8'($urandom % 72);
      report_done  = ($urandom % 4 == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
